// File: rtl/muldiv_unit.sv
// Iterative radix-2 MIPS multiply/divide unit with HI/LO result registers.
// 32 shift-add or restoring-subtract steps on operand magnitudes, then one sign-fix cycle.
module muldiv_unit #(
  parameter int ITERS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        hi_we,
  input  logic        lo_we,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t      state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic [1:0]  op_q, op_d;
  logic        sq_q, sq_d, sr_q, sr_d;
  logic [31:0] a_q, a_d;        // DIV: dividend shifting out, quotient shifting in
  logic [31:0] b_q, b_d;        // MUL: multiplier shifting right; DIV: divisor
  logic [63:0] mcand_q, mcand_d;
  logic [63:0] acc_q, acc_d;    // MUL: product; DIV: remainder in [32:0]
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        done_q, done_d;

  logic        sa, sb;
  logic [31:0] mag_a, mag_b;
  logic [33:0] diff;

  // op[0]=0 selects the signed forms; the magnitude of 80000000 is itself as unsigned
  assign sa    = ~op[0] & rs_data[31];
  assign sb    = ~op[0] & rt_data[31];
  assign mag_a = sa ? -rs_data : rs_data;
  assign mag_b = sb ? -rt_data : rt_data;
  assign diff  = {1'b0, acc_q[31:0], a_q[31]} - {2'b00, b_q};

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    op_d    = op_q;
    sq_d    = sq_q;
    sr_d    = sr_q;
    a_d     = a_q;
    b_d     = b_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = op;
          sq_d    = sa ^ sb;
          sr_d    = sa;
          // Divide by zero: quotient stays all-ones; negating |rs| restores the raw rs in HI
          if (op[1] && rt_data == 32'd0) sq_d = 1'b0;
          a_d     = mag_a;
          b_d     = mag_b;
          mcand_d = {32'd0, mag_a};
          acc_d   = 64'd0;
          count_d = 5'd0;
          state_d = RUN;
        end else begin
          if (hi_we) hi_d = rs_data;
          if (lo_we) lo_d = rs_data;
        end
      end
      RUN: begin
        if (op_q[1]) begin
          if (!diff[33]) acc_d = {31'd0, diff[32:0]};
          else           acc_d = {31'd0, acc_q[31:0], a_q[31]};
          a_d = {a_q[30:0], ~diff[33]};
        end else begin
          if (b_q[0]) acc_d = acc_q + mcand_q;
          mcand_d = mcand_q << 1;
          b_d     = b_q >> 1;
        end
        count_d = count_q + 5'd1;
        if (count_q == 5'(ITERS - 1)) state_d = FIX;
      end
      FIX: begin
        if (op_q[1]) begin
          lo_d = sq_q ? -a_q : a_q;
          hi_d = sr_q ? -acc_q[31:0] : acc_q[31:0];
        end else begin
          {hi_d, lo_d} = sq_q ? -acc_q : acc_q;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= 5'd0;
      op_q    <= 2'd0;
      sq_q    <= 1'b0;
      sr_q    <= 1'b0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      mcand_q <= 64'd0;
      acc_q   <= 64'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      op_q    <= op_d;
      sq_q    <= sq_d;
      sr_q    <= sr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed table, hand-written control sequences, and
// randomized ops against an arithmetic reference model.
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] rs_data = 32'd0, rt_data = 32'd0;
  logic        hi_we = 1'b0, lo_we = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_hi = 32'd0, exp_lo = 32'd0;

  muldiv_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data), .hi_we(hi_we), .lo_we(lo_we),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
    string       nm;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, got, want);
    end
  endtask

  // Reference: MIPS results from plain 64-bit arithmetic, {hi, lo}
  function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint x, y, q, r;
    logic [63:0] ua, ub, p;
    x = $signed(a);
    y = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (o)
      2'd0: begin p = x * y; return p; end
      2'd1: return ua * ub;
      2'd2: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        q = x / y;
        r = x % y;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        p = ua / ub;
        ua = ua % ub;
        return {ua[31:0], p[31:0]};
      end
    endcase
  endfunction

  // Launch one op and follow it to completion. interfere: mid-run start/MT writes;
  // mt_start: assert hi_we/lo_we together with start.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] want, input string nm,
                        input bit interfere, input bit mt_start);
    int edges, bcnt;
    bit moved;
    @(negedge clk);
    start = 1'b1; op = o; rs_data = a; rt_data = b;
    hi_we = mt_start; lo_we = mt_start;
    @(posedge clk); #1;
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    rs_data = $urandom; rt_data = $urandom;
    edges = 1; bcnt = 0; moved = 1'b0;
    while (!done && edges < 100) begin
      if (busy) bcnt++;
      if (hi !== exp_hi || lo !== exp_lo) moved = 1'b1;
      if (interfere && edges == 5) begin
        start = 1'b1; op = 2'($urandom); hi_we = 1'b1; lo_we = 1'b1;
      end else begin
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      end
      @(posedge clk); #1;
      edges++;
    end
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    chk({nm, " latency"}, 64'(edges), 64'd34);
    chk({nm, " busy cycles"}, 64'(bcnt), 64'd33);
    chk({nm, " hi/lo held during run"}, {63'd0, moved}, 64'd0);
    chk({nm, " result"}, {hi, lo}, want);
    chk({nm, " busy low at done"}, {63'd0, busy}, 64'd0);
    exp_hi = want[63:32];
    exp_lo = want[31:0];
    @(posedge clk); #1;
    chk({nm, " done one-cycle"}, {63'd0, done}, 64'd0);
  endtask

  initial begin
    logic [31:0] pick[6];
    logic [31:0] ra, rb;
    logic [1:0]  ro;

    tbl[0] = '{2'd0, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, "mult_neg3x7"};
    tbl[1] = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max"};
    tbl[2] = '{2'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg7by2"};
    tbl[3] = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div_overflow"};
    tbl[4] = '{2'd3, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF, "divu_by0"};
    tbl[5] = '{2'd3, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, "divu_100by7"};
    tbl[6] = '{2'd2, 32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFF8, 32'hFFFFFFFF, "div_neg_by0"};
    tbl[7] = '{2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, "mult_minxmin"};
    tbl[8] = '{2'd2, 32'h80000000, 32'h00000002, 32'h00000000, 32'hC0000000, "div_min_by2"};

    #2;
    chk("reset busy", {63'd0, busy}, 64'd0);
    chk("reset done", {63'd0, done}, 64'd0);
    chk("reset hi/lo", {hi, lo}, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    foreach (tbl[i])
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, {tbl[i].hi, tbl[i].lo}, tbl[i].nm, 1'b0, 1'b0);

    // MTHI while idle
    @(negedge clk);
    hi_we = 1'b1; rs_data = 32'h12345678;
    @(posedge clk); #1;
    hi_we = 1'b0;
    chk("mthi hi", {32'd0, hi}, 64'h12345678);
    chk("mthi lo kept", {32'd0, lo}, {32'd0, exp_lo});
    chk("mthi no done", {63'd0, done}, 64'd0);
    exp_hi = 32'h12345678;

    // MTHI+MTLO together
    @(negedge clk);
    hi_we = 1'b1; lo_we = 1'b1; rs_data = 32'hA5A5F00D;
    @(posedge clk); #1;
    hi_we = 1'b0; lo_we = 1'b0;
    chk("mt both", {hi, lo}, 64'hA5A5F00D_A5A5F00D);
    exp_hi = 32'hA5A5F00D; exp_lo = 32'hA5A5F00D;

    // MTLO and second start while busy are ignored
    run_op(2'd3, 32'h00000064, 32'h00000007, 64'h00000002_0000000E, "busy_interfere", 1'b1, 1'b0);
    // start together with MT write: start wins, MT write never lands
    run_op(2'd1, 32'h00010001, 32'h00000003, 64'h00000000_00030003, "start_with_mt", 1'b0, 1'b1);

    // Async reset mid-MULT
    @(negedge clk);
    start = 1'b1; op = 2'd0; rs_data = 32'h7FFFFFFF; rt_data = 32'h12345678;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("midop reset busy", {63'd0, busy}, 64'd0);
    chk("midop reset done", {63'd0, done}, 64'd0);
    chk("midop reset hi/lo", {hi, lo}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    exp_hi = 32'd0; exp_lo = 32'd0;
    run_op(2'd1, 32'd3, 32'd5, 64'h00000000_0000000F, "after_reset_multu", 1'b0, 1'b0);

    // Randomized ops with corner-biased operands
    for (int n = 0; n < 40; n++) begin
      pick[0] = 32'd0; pick[1] = 32'd1; pick[2] = 32'hFFFFFFFF;
      pick[3] = 32'h80000000; pick[4] = 32'h7FFFFFFF; pick[5] = $urandom;
      ra = ($urandom_range(0, 2) == 0) ? pick[$urandom_range(0, 5)] : $urandom;
      rb = ($urandom_range(0, 2) == 0) ? pick[$urandom_range(0, 5)] : $urandom;
      if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(1, 31);
      ro = 2'($urandom);
      run_op(ro, ra, rb, ref_model(ro, ra, rb), $sformatf("rand%0d_op%0d", n, ro), 1'b0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
